rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between NUM_REQ writeback sources (ALU, load unit, CSR unit, ...).
- Each source offers a reg_transport_t (5-bit addr, 32-bit value) on a valid/ready handshake.
- The block picks one source per cycle by round-robin and registers the winner into a one-entry output stage, which drives the register-file write port.
- It sits between the execute/memory stages and the register file.

---
 rtl/rf_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between NUM_REQ writeback sources.
// Optional write-stage forwarding lookups are enabled by defining RF_WB_ARBITER_FWD_EN.
package rf_wb_arbiter_pkg;
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] value;
    } reg_transport_t;
endpackage

module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic           [NUM_REQ-1:0]  req_valid,
    input  reg_transport_t [NUM_REQ-1:0]  req_data,
    output logic           [NUM_REQ-1:0]  req_ready,
    input  logic                          wb_stall,
    output logic                          wb_valid,
    output reg_transport_t                wb_data,
    output logic           [PTR_W-1:0]    grant_idx
`ifdef RF_WB_ARBITER_FWD_EN
    ,
    input  logic           [4:0]          fwd_addr_a,
    input  logic           [4:0]          fwd_addr_b,
    output logic                          fwd_hit_a,
    output logic                          fwd_hit_b,
    output logic           [31:0]         fwd_value_a,
    output logic           [31:0]         fwd_value_b
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    stage_e                state_q, state_d;
    reg_transport_t        data_q,  data_d;
    logic    [PTR_W-1:0]   ptr_q,   ptr_d;
    logic    [PTR_W-1:0]   grant_q, grant_d;

    logic                  can_accept;
    logic                  win_found;
    logic    [PTR_W-1:0]   win_idx;
    logic                  handshake;

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned      offset);
        int unsigned sum;
        sum = (32'(base) + offset) % NUM_REQ;
        return PTR_W'(sum);
    endfunction

    assign can_accept = (state_q == ST_EMPTY) || !wb_stall;

    // Search starts one past the last winner so the last winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req_valid[rr_idx(ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_idx(ptr_q, k);
            end
        end
    end

    assign handshake = can_accept && win_found;

    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        if (state_q == ST_FULL && !wb_stall) begin
            state_d = ST_EMPTY;
        end
        if (handshake) begin
            ptr_d   = win_idx;
            grant_d = win_idx;
            // Writes to x0 complete the handshake but never occupy the stage.
            if (req_data[win_idx].addr != 5'd0) begin
                data_d  = req_data[win_idx];
                state_d = ST_FULL;
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign wb_valid  = (state_q == ST_FULL);
    assign wb_data   = data_q;
    assign grant_idx = grant_q;

`ifdef RF_WB_ARBITER_FWD_EN
    // Covers the pending write even while it is held under wb_stall.
    assign fwd_hit_a   = wb_valid && (data_q.addr == fwd_addr_a) && (fwd_addr_a != 5'd0);
    assign fwd_hit_b   = wb_valid && (data_q.addr == fwd_addr_b) && (fwd_addr_b != 5'd0);
    assign fwd_value_a = fwd_hit_a ? data_q.value : '0;
    assign fwd_value_b = fwd_hit_b ? data_q.value : '0;
`endif

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_stall_hold:   assert property (@(posedge clk) disable iff (rst)
                                     (wb_valid && wb_stall) |=> (wb_valid && $stable(wb_data)));
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: scenario tasks with inline checks plus a
// queue-based scoreboard that predicts req_ready and the write-port stage every cycle.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int NREQ = 3;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic           [NREQ-1:0]   req_valid = '0;
    reg_transport_t [NREQ-1:0]   req_data  = '0;
    logic           [NREQ-1:0]   req_ready;
    logic                        wb_stall = 1'b0;
    logic                        wb_valid;
    reg_transport_t              wb_data;
    logic           [1:0]        grant_idx;
`ifdef RF_WB_ARBITER_FWD_EN
    logic [4:0]  fwd_addr_a = '0;
    logic [4:0]  fwd_addr_b = '0;
    logic        fwd_hit_a, fwd_hit_b;
    logic [31:0] fwd_value_a, fwd_value_b;
`endif

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.NUM_REQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_stall  (wb_stall),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .grant_idx (grant_idx)
`ifdef RF_WB_ARBITER_FWD_EN
        ,
        .fwd_addr_a  (fwd_addr_a),
        .fwd_addr_b  (fwd_addr_b),
        .fwd_hit_a   (fwd_hit_a),
        .fwd_hit_b   (fwd_hit_b),
        .fwd_value_a (fwd_value_a),
        .fwd_value_b (fwd_value_b)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        int             idx;
        reg_transport_t data;
    } sb_entry_t;

    sb_entry_t      sb_q[$];
    int             m_ptr   = NREQ - 1;
    int             m_grant = 0;
    bit             m_full  = 1'b0;
    reg_transport_t m_data  = '0;

    logic [NREQ-1:0] mon_exp_ready;
    bit              mon_can, mon_found;
    int              mon_win;
    sb_entry_t       mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (wb_valid !== m_full) begin
                errors++;
                $display("FAIL sb_wb_valid: got %b expected %b at %0t", wb_valid, m_full, $time);
            end
            checks++;
            if (wb_data !== m_data) begin
                errors++;
                $display("FAIL sb_wb_data: got %h expected %h at %0t", wb_data, m_data, $time);
            end
            checks++;
            if (grant_idx !== 2'(m_grant)) begin
                errors++;
                $display("FAIL sb_grant_idx: got %0d expected %0d at %0t", grant_idx, m_grant, $time);
            end
            mon_can   = !m_full || !wb_stall;
            mon_found = 1'b0;
            mon_win   = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!mon_found && req_valid[(m_ptr + k) % NREQ]) begin
                    mon_found = 1'b1;
                    mon_win   = (m_ptr + k) % NREQ;
                end
            end
            mon_exp_ready = '0;
            if (mon_can && mon_found) begin
                mon_exp_ready[mon_win] = 1'b1;
                mon_e.idx  = mon_win;
                mon_e.data = req_data[mon_win];
                sb_q.push_back(mon_e);
            end
            checks++;
            if (req_ready !== mon_exp_ready) begin
                errors++;
                $display("FAIL sb_req_ready: got %b expected %b at %0t", req_ready, mon_exp_ready, $time);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr   = NREQ - 1;
            m_grant = 0;
            m_full  = 1'b0;
            m_data  = '0;
            sb_q.delete();
        end else begin
            if (m_full && !wb_stall) m_full = 1'b0;
            if (sb_q.size() > 0) begin
                mon_e   = sb_q.pop_front();
                m_ptr   = mon_e.idx;
                m_grant = mon_e.idx;
                if (mon_e.data.addr != 5'd0) begin
                    m_full = 1'b1;
                    m_data = mon_e.data;
                end else begin
                    m_full = 1'b0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        wb_stall = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid);
        end
        checks++;
        if (wb_data !== 37'd0) begin
            errors++; $display("FAIL reset_wb_data: got %h expected 0", wb_data);
        end
        checks++;
        if (grant_idx !== 2'd0) begin
            errors++; $display("FAIL reset_grant_idx: got %0d expected 0", grant_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        req_valid   = 3'b001;
        req_data[0] = '{addr: 5'd5, value: 32'hDEADBEEF};
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL single_ready: got %b expected 001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== {5'd5, 32'hDEADBEEF} || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h g=%0d expected v=1 d=%h g=0",
                     wb_valid, wb_data, grant_idx, {5'd5, 32'hDEADBEEF});
        end
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL single_idle: got %b expected 0", wb_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_r;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i] = '{addr: 5'(i + 1), value: 32'h1000 + 32'(i)};
        end
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_r = '0;
            exp_r[k % 3] = 1'b1;
            @(negedge clk);
            checks++;
            if (req_ready !== exp_r) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_r);
            end
            tick();
            checks++;
            if (wb_valid !== 1'b1 || grant_idx !== 2'(k % 3) || wb_data.addr !== 5'(k % 3 + 1)) begin
                errors++;
                $display("FAIL rr_out[%0d]: got v=%b g=%0d a=%0d expected v=1 g=%0d a=%0d",
                         k, wb_valid, grant_idx, wb_data.addr, k % 3, k % 3 + 1);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_stall_hold();
        req_valid   = 3'b001;
        req_data[0] = '{addr: 5'd7, value: 32'h1234};
        tick();
        req_valid   = 3'b010;
        req_data[1] = '{addr: 5'd8, value: 32'hBEEF};
        wb_stall    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 3'b000 || wb_valid !== 1'b1 || wb_data !== {5'd7, 32'h1234}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got r=%b v=%b d=%h expected r=000 v=1 d=%h",
                         k, req_ready, wb_valid, wb_data, {5'd7, 32'h1234});
            end
            tick();
        end
        wb_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin
            errors++; $display("FAIL stall_release_ready: got %b expected 010", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== {5'd8, 32'hBEEF} || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL stall_release_out: got v=%b d=%h g=%0d expected v=1 d=%h g=1",
                     wb_valid, wb_data, grant_idx, {5'd8, 32'hBEEF});
        end
        tick();
    endtask

    task automatic test_x0_drop();
        req_valid   = 3'b100;
        req_data[2] = '{addr: 5'd0, value: 32'hFFFFFFFF};
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b100) begin
            errors++; $display("FAIL x0_ready: got %b expected 100", req_ready);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b0 || grant_idx !== 2'd2 || wb_data !== {5'd8, 32'hBEEF}) begin
            errors++;
            $display("FAIL x0_out: got v=%b g=%0d d=%h expected v=0 g=2 d=%h",
                     wb_valid, grant_idx, wb_data, {5'd8, 32'hBEEF});
        end
        req_data[2] = '{addr: 5'd3, value: 32'h3};
        req_valid   = 3'b111;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL x0_next_ready: got %b expected 001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_async_reset();
        req_valid   = 3'b001;
        req_data[0] = '{addr: 5'd9, value: 32'hA5A5A5A5};
        tick();
        req_valid = '0;
        wb_stall  = 1'b1;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== {5'd9, 32'hA5A5A5A5}) begin
            errors++; $display("FAIL areset_pre: got v=%b d=%h expected v=1 d=%h",
                               wb_valid, wb_data, {5'd9, 32'hA5A5A5A5});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || wb_data !== 37'd0) begin
            errors++; $display("FAIL areset_async: got v=%b d=%h expected v=0 d=0", wb_valid, wb_data);
        end
        tick();
        rst       = 1'b0;
        wb_stall  = 1'b0;
        req_valid = 3'b111;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL areset_first_grant: got %b expected 001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

`ifdef RF_WB_ARBITER_FWD_EN
    task automatic test_fwd();
        req_valid   = 3'b001;
        req_data[0] = '{addr: 5'd4, value: 32'h55};
        tick();
        req_valid  = '0;
        wb_stall   = 1'b1;
        fwd_addr_a = 5'd4;
        fwd_addr_b = 5'd0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (fwd_hit_a !== 1'b1 || fwd_value_a !== 32'h55 || fwd_hit_b !== 1'b0 || fwd_value_b !== 32'h0) begin
                errors++;
                $display("FAIL fwd_hit[%0d]: got ha=%b va=%h hb=%b vb=%h expected ha=1 va=55 hb=0 vb=0",
                         k, fwd_hit_a, fwd_value_a, fwd_hit_b, fwd_value_b);
            end
            tick();
        end
        fwd_addr_a = 5'd5;
        #1;
        checks++;
        if (fwd_hit_a !== 1'b0 || fwd_value_a !== 32'h0) begin
            errors++; $display("FAIL fwd_miss: got ha=%b va=%h expected ha=0 va=0", fwd_hit_a, fwd_value_a);
        end
        wb_stall = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_stall_hold();
        test_x0_drop();
        test_async_reset();
`ifdef RF_WB_ARBITER_FWD_EN
        test_fwd();
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
